// File: rtl/neural_network_4x4.sv
// neural_network_4x4
//   Byte-serial single-layer perceptron: four neurons, four 8-bit inputs.
//   The host streams x3..x0, then 24 parameter bytes (per neuron 3..0:
//   th, b, w3, w2, w1, w0), advancing phases with rising edges of `changes`.
//   Four compute cycles evaluate one neuron each; the result is registered.
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous, active-low reset
//   changes          phase-advance strobe (rising edge acted on)
//   data_in[7:0]     input / parameter byte, one per clock in LOAD_X/LOAD_P
//   network_outputs  [3:0] fire flags, [5:4] argmax index, [6] 0, [7] valid
//
// Build option
//   NN_SIGNED_EN     when defined, x/w/b/th are two's-complement and all
//                    arithmetic, threshold compare and argmax are signed.
//
// state   | meaning
// --------+--------------------------------------------------------------
// LOAD_X  | shift bytes into the 4-byte input register
// LOAD_P  | shift bytes into the 24-byte parameter register
// COMPUTE | four cycles, neuron k evaluated in cycle k
// DONE    | result held until the next strobe edge clears valid

module neural_network_4x4 (
  input  logic       clk,
  input  logic       reset,
  input  logic       changes,
  input  logic [7:0] data_in,
  output logic [7:0] network_outputs
);

  typedef enum logic [1:0] {
    LOAD_X  = 2'd0,
    LOAD_P  = 2'd1,
    COMPUTE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        changes_q;
  logic        change_edge;

  // x_q[0] is the newest byte (x0); p_q[0] is the newest byte (w00).
  // Neuron k lives at p_q[6k +: 6] = {th, b, w3, w2, w1, w0}.
  logic [7:0]  x_q [4];
  logic [7:0]  p_q [24];

  logic [1:0]  cnt_q;
  logic [1:0]  neuron;
  logic [3:0]  fire_q;
  logic [18:0] max_q;
  logic [1:0]  max_idx_q;

  logic        shift_x, shift_p, start_compute, last_cycle, clear_valid;

  logic [4:0]  base;
  logic [18:0] sum;
  logic [18:0] th_ext;
  logic        fire_bit;
  logic        take_max;
  logic [3:0]  fire_next;
  logic [1:0]  idx_next;

  assign change_edge = changes & ~changes_q;

  // Down-counter runs 3..0, so the neuron under evaluation is 3 - cnt.
  assign neuron = 2'd3 - cnt_q;

  function automatic logic [18:0] ext(input logic [7:0] v);
`ifdef NN_SIGNED_EN
    return {{11{v[7]}}, v};
`else
    return {11'd0, v};
`endif
  endfunction

  function automatic logic gt(input logic [18:0] a, input logic [18:0] b);
`ifdef NN_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= LOAD_X;
      changes_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      changes_q <= changes;
    end
  end

  always_comb begin
    state_d       = state_q;
    shift_x       = 1'b0;
    shift_p       = 1'b0;
    start_compute = 1'b0;
    last_cycle    = 1'b0;
    clear_valid   = 1'b0;
    case (state_q)
      LOAD_X: begin
        shift_x = 1'b1;
        if (change_edge) state_d = LOAD_P;
      end
      LOAD_P: begin
        shift_p = 1'b1;
        if (change_edge) begin
          state_d       = COMPUTE;
          start_compute = 1'b1;
        end
      end
      COMPUTE: begin
        if (cnt_q == 2'd0) begin
          last_cycle = 1'b1;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (change_edge) begin
          clear_valid = 1'b1;
          state_d     = LOAD_X;
        end
      end
      default: state_d = LOAD_X;
    endcase
  end

  // ------------------------------------------------------- neuron datapath
  // Full 19-bit arithmetic: the true sum always fits, so wrapping the
  // 19x19 products to 19 bits gives the exact result in both modes.
  always_comb begin
    base = 5'(neuron) * 5'd6;
    sum  = ext(p_q[base + 5'd4]);
    for (int i = 0; i < 4; i++) begin
      sum = sum + ext(p_q[base + 5'(i)]) * ext(x_q[i]);
    end
    th_ext   = ext(p_q[base + 5'd5]);
    fire_bit = gt(sum, th_ext);
    // Strict compare keeps the lower index on ties; neuron 0 seeds the max.
    take_max = (neuron == 2'd0) || gt(sum, max_q);
    fire_next         = fire_q;
    fire_next[neuron] = fire_bit;
    idx_next = take_max ? neuron : max_idx_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++)  x_q[i] <= 8'd0;
      for (int i = 0; i < 24; i++) p_q[i] <= 8'd0;
      cnt_q           <= 2'd0;
      fire_q          <= 4'd0;
      max_q           <= 19'd0;
      max_idx_q       <= 2'd0;
      network_outputs <= 8'h00;
    end else begin
      if (shift_x) begin
        x_q[0] <= data_in;
        for (int i = 1; i < 4; i++) x_q[i] <= x_q[i-1];
      end
      if (shift_p) begin
        p_q[0] <= data_in;
        for (int i = 1; i < 24; i++) p_q[i] <= p_q[i-1];
      end
      if (start_compute) begin
        cnt_q <= 2'd3;
      end else if (state_q == COMPUTE) begin
        cnt_q  <= cnt_q - 2'd1;
        fire_q <= fire_next;
        if (take_max) begin
          max_q     <= sum;
          max_idx_q <= neuron;
        end
      end
      if (last_cycle) begin
        network_outputs <= {1'b1, 1'b0, idx_next, fire_next};
      end else if (clear_valid) begin
        network_outputs[7] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_neural_network_4x4.sv
// Directed + randomized bench for neural_network_4x4. Expected results come
// from constants and from a plain integer perceptron model.
module tb_neural_network_4x4;

  logic       clk = 1'b0;
  logic       reset;
  logic       changes;
  logic [7:0] data_in;
  logic [7:0] network_outputs;

  int errors = 0;
  int checks = 0;

  // Host-side view of the operands: xb[i] = x_i, wb[k][i] = w_ki.
  logic [7:0] xb  [4];
  logic [7:0] thb [4];
  logic [7:0] bb  [4];
  logic [7:0] wb  [4][4];

  always #5 clk = ~clk;

  neural_network_4x4 dut (
    .clk             (clk),
    .reset           (reset),
    .changes         (changes),
    .data_in         (data_in),
    .network_outputs (network_outputs)
  );

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int val(input logic [7:0] v);
`ifdef NN_SIGNED_EN
    return int'($signed(v));
`else
    return int'(v);
`endif
  endfunction

  // Reference: fire = sum > th, argmax with first (lowest) index winning ties.
  function automatic logic [7:0] model();
    int s [4];
    int best;
    int bi;
    logic [7:0] r;
    r = 8'h80;
    for (int k = 0; k < 4; k++) begin
      s[k] = val(bb[k]);
      for (int i = 0; i < 4; i++) s[k] += val(wb[k][i]) * val(xb[i]);
      if (s[k] > val(thb[k])) r[k] = 1'b1;
    end
    best = s[0];
    bi   = 0;
    for (int k = 1; k < 4; k++) begin
      if (s[k] > best) begin
        best = s[k];
        bi   = k;
      end
    end
    r[5:4] = 2'(bi);
    return r;
  endfunction

  task automatic send(input logic [7:0] b, input logic ch);
    @(negedge clk);
    data_in = b;
    changes = ch;
  endtask

  // Streams x3..x0 (strobe on x0, held xhold cycles), then 24 parameter
  // bytes with the strobe on the final byte w00.
  task automatic load(input int xhold);
    for (int i = 3; i >= 0; i--) send(xb[i], i == 0);
    for (int j = 1; j < xhold; j++) send(8'($urandom), 1'b1);
    for (int k = 3; k >= 0; k--) begin
      send(thb[k], 1'b0);
      send(bb[k], 1'b0);
      for (int i = 3; i >= 0; i--) send(wb[k][i], (k == 0) && (i == 0));
    end
  endtask

  // Called right after load(): E is the next posedge.
  task automatic run(input string tag, input logic [7:0] exp, input bit pulse);
    send(8'($urandom), 1'b0);   // after E
    send(8'($urandom), pulse);  // after E+1; optional strobe inside COMPUTE
    send(8'($urandom), 1'b0);   // after E+2
    check({tag, "/valid_e2"}, {7'd0, network_outputs[7]}, 8'h00);
    @(negedge clk);             // after E+3
    check({tag, "/valid_e3"}, {7'd0, network_outputs[7]}, 8'h00);
    @(negedge clk);             // after E+4
    check({tag, "/result"}, network_outputs, exp);
    @(negedge clk);
    check({tag, "/hold"}, network_outputs, exp);
    send(8'($urandom), 1'b1);
    send(8'($urandom), 1'b0);
    check({tag, "/exit"}, network_outputs, {1'b0, exp[6:0]});
  endtask

  task automatic set_base();
    xb[0] = 8'd7; xb[1] = 8'd8; xb[2] = 8'd9; xb[3] = 8'd10;
    for (int k = 0; k < 4; k++) begin
      thb[k] = 8'd0;
      bb[k]  = 8'(k + 1);
      for (int i = 0; i < 4; i++) wb[k][i] = 8'(k + 1);
    end
  endtask

  task automatic set_random();
    for (int i = 0; i < 4; i++) xb[i] = 8'($urandom);
    for (int k = 0; k < 4; k++) begin
      thb[k] = 8'($urandom);
      bb[k]  = 8'($urandom);
      for (int i = 0; i < 4; i++) wb[k][i] = 8'($urandom);
    end
  endtask

  initial begin
    reset   = 1'b0;
    changes = 1'b0;
    data_in = 8'd0;
    repeat (3) @(negedge clk);
    check("reset", network_outputs, 8'h00);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    check("idle", network_outputs, 8'h00);

    set_base();
    load(1);
    run("base", 8'hBF, 1'b0);

    thb[0] = 8'd35;
    load(1);
    run("th35", 8'hBE, 1'b0);

    thb[0] = 8'd34;
    load(5);
    run("th34_hold5_pulse", 8'hBF, 1'b1);

    for (int k = 0; k < 4; k++) begin
      thb[k] = 8'd0;
      bb[k]  = 8'd1;
      for (int i = 0; i < 4; i++) wb[k][i] = 8'd1;
    end
    load(1);
    run("tie", 8'h8F, 1'b0);

    // Reset during compute cycle 2; previous result bits are still visible.
    set_random();
    load(1);
    send(8'd0, 1'b0);
    send(8'd0, 1'b0);
    @(negedge clk);
    #1 reset = 1'b0;
    #1 check("mid_reset", network_outputs, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    check("mid_reset_idle", network_outputs, 8'h00);
    load(1);
    run("reload", model(), 1'b0);

`ifdef NN_SIGNED_EN
    for (int i = 0; i < 4; i++) xb[i] = 8'd0;
    xb[0] = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      thb[k] = 8'd0;
      bb[k]  = 8'd0;
      for (int i = 0; i < 4; i++) wb[k][i] = 8'd0;
    end
    wb[0][0] = 8'd1;
    load(1);
    run("signed_neg", 8'h90, 1'b0);
`endif

    for (int t = 0; t < 8; t++) begin
      set_random();
      load(1 + (t % 3));
      run($sformatf("rand%0d", t), model(), t[0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
